systolic_ctrl: RTL
==================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for a ROWS x COLS weight-stationary array of mac_unit PEs. On start it
//  pulses the array clear, then shifts one weight tile down the columns with ld_weight
//  held ROWS cycles. It then streams n_vec activation vectors with a per-row 1-cycle
//  skew and flags when each column's bottom out_sum holds a valid result.
//  Sits between the weight/activation SRAMs, the row skew registers and the array.
// PARAMETERS
//  ROWS      4   PE rows (weight-load depth, input skew span)
//  COLS      4   PE columns (output skew span)
//  VEC_W     8   width of n_vec and the vector index counters
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-high
//  start        in   1          1-cycle request; sampled only in IDLE
//  reuse_w      in   1          with start: skip LOAD_W if w_valid=1
//  n_vec        in   VEC_W      vectors to stream; latched on start
//  busy         out  1          high in every state except IDLE
//  done         out  1          1-cycle pulse on DONE
//  w_valid      out  1          array holds a complete weight tile
//  arr_clr      out  1          drives mac reset (synchronous clear of out_data/out_sum)
//  ld_weight    out  1          drives mac ld_weight on all PEs
//  wt_rd_en     out  1          weight SRAM read strobe (1-cycle read latency)
//  wt_rd_row    out  clog2(ROWS) weight row address
//  act_rd_en    out  1          activation SRAM read strobe (1-cycle latency)
//  act_rd_addr  out  VEC_W      activation vector index
//  row_valid    out  ROWS       [r]: row r in_data is a live element this cycle
//  col_valid    out  COLS       [c]: column c bottom out_sum is a result this cycle
//  out_vec      out  VEC_W      vector index of the result on col_valid[0]
// BEHAVIOUR
//  - Reset (async): state=IDLE; every output 0; w_valid=0; all counters and delay lines 0.
//  - FSM: IDLE -> CLEAR -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 latches n_vec. If reuse_w=1 and w_valid=1, go to STREAM (no CLEAR).
//    Otherwise go to CLEAR. start in any other state is ignored.
//  - CLEAR: arr_clr=1 for exactly 1 cycle; w_valid<=0; then LOAD_W.
//  - LOAD_W: ROWS+1 cycles. wt_rd_en=1 for cycles t=0..ROWS-1, wt_rd_row=ROWS-1-t
//    (bottom row first). ld_weight=1 for cycles t=1..ROWS (aligned to read data).
//    After the last ld_weight, PE row r holds the weight read at t=ROWS-1-r.
//    On exit w_valid<=1.
//  - STREAM: n_vec cycles. act_rd_en=1, act_rd_addr=0..n_vec-1 (one per cycle).
//    issue = act_rd_en delayed 1 cycle; row_valid[r] = issue delayed r cycles.
//    col_valid[c] = issue delayed ROWS+c cycles.
//    out_vec increments on each col_valid[0] from 0.
//  - n_vec=0: STREAM is skipped; DRAIN exits immediately; done still pulses.
//  - DRAIN: wait until the delay lines are empty (last col_valid[COLS-1] seen);
//    then DONE. Latency from last act_rd_en to last col_valid = 1+ROWS+COLS-1 cycles.
//  - DONE: done=1 for 1 cycle; busy=0 next cycle; w_valid persists.
//  - ld_weight and arr_clr are never high in STREAM or DRAIN.
//    row_valid and col_valid are never high in LOAD_W.
//  - reset mid-operation: immediate return to IDLE, all outputs 0, w_valid=0.
//    The next start is forced down the CLEAR path.
//  - Counters are VEC_W/clog2 wide with no wrap; n_vec max 2^VEC_W-1.
// STRUCTURE
//  - systolic_pkg: ctrl_state_e enum {IDLE,CLEAR,LOAD_W,STREAM,DRAIN,DONE}; clog2 helpers.
//  - Sub-module ctrl_delay_line #(DEPTH): 1-bit shift register with parallel taps.
//    One instance (DEPTH=ROWS+COLS) generates row_valid/col_valid from issue.
//    Its empty flag drives the DRAIN exit.
// TESTING
//  1. ROWS=COLS=4, start with n_vec=3 -> arr_clr 1 cycle, then wt_rd_row 3,2,1,0.
//     ld_weight high 4 cycles; act_rd_addr 0,1,2; col_valid[3] last high 8 cycles
//     after act_rd_addr=2; done pulse; busy low.
//  2. Scoreboard with 4x4 mac_unit array and known W, X -> column sums equal X*W
//     for all 3 vectors, tagged by out_vec 0..2.
//  3. Second start with reuse_w=1 after test 1 -> no arr_clr, no ld_weight; STREAM starts
//     the cycle after start; results match the same W.
//  4. start with n_vec=0 -> CLEAR and LOAD_W run; no act_rd_en, no row/col_valid;
//     done pulses; w_valid=1.
//  5. start pulsed during STREAM -> ignored (n_vec unchanged, single done).
//  6. reset asserted mid-LOAD_W -> all outputs 0 asynchronously, w_valid=0.
//     Later start with reuse_w=1 still takes the CLEAR path.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_e;

    localparam int ROWS_DEF  = 4;
    localparam int COLS_DEF  = 4;
    localparam int VEC_W_DEF = 8;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Control/status bundle between the sequencer, its requester, the SRAMs and the array.
interface systolic_ctrl_if
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int VEC_W = VEC_W_DEF
);
    localparam int RW = idx_w(ROWS);

    logic             start;
    logic             reuse_w;
    logic [VEC_W-1:0] n_vec;
    logic             busy;
    logic             done;
    logic             w_valid;
    logic             arr_clr;
    logic             ld_weight;
    logic             wt_rd_en;
    logic [RW-1:0]    wt_rd_row;
    logic             act_rd_en;
    logic [VEC_W-1:0] act_rd_addr;
    logic [ROWS-1:0]  row_valid;
    logic [COLS-1:0]  col_valid;
    logic [VEC_W-1:0] out_vec;

    modport master (
        output start, reuse_w, n_vec,
        input  busy, done, w_valid, arr_clr, ld_weight, wt_rd_en, wt_rd_row,
               act_rd_en, act_rd_addr, row_valid, col_valid, out_vec
    );

    modport slave (
        input  start, reuse_w, n_vec,
        output busy, done, w_valid, arr_clr, ld_weight, wt_rd_en, wt_rd_row,
               act_rd_en, act_rd_addr, row_valid, col_valid, out_vec
    );

endinterface

// File: rtl/systolic_ctrl_delay_line.sv
// 1-bit shift register with every stage exposed; taps[k] is din delayed k+1 cycles.
module systolic_ctrl_delay_line
    import systolic_ctrl_pkg::*;
#(
    parameter int DEPTH = ROWS_DEF + COLS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [DEPTH-1:0] taps,
    output logic             empty
);
    logic [DEPTH-1:0] taps_q, taps_d;

    // Shift toward the high taps by one stage per cycle.
    always_comb begin
        taps_d = {taps_q[DEPTH-2:0], din};
    end

    // Stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps  = taps_q;
    assign empty = ~|taps_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary MAC array: clear, weight load, skewed
// activation stream and drain, with all control outputs registered.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    systolic_ctrl_if.slave bus
);
    localparam int RW    = idx_w(ROWS);
    localparam int DEPTH = ROWS + COLS;

    ctrl_state_e      state_q, state_d;
    logic [VEC_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] n_vec_q, n_vec_d;
    logic [VEC_W-1:0] out_vec_q, out_vec_d;
    logic [VEC_W-1:0] act_rd_addr_q, act_rd_addr_d;
    logic [RW-1:0]    wt_rd_row_q, wt_rd_row_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             w_valid_q, w_valid_d;
    logic             arr_clr_q, arr_clr_d;
    logic             ld_weight_q, ld_weight_d;
    logic             wt_rd_en_q, wt_rd_en_d;
    logic             act_rd_en_q, act_rd_en_d;

    logic [DEPTH-1:0] taps;
    logic             dl_empty;

    // Issue pipeline: taps[0] is the cycle the activation read data arrives.
    systolic_ctrl_delay_line #(.DEPTH(DEPTH)) u_dl (
        .clk   (clk),
        .reset (reset),
        .din   (act_rd_en_q),
        .taps  (taps),
        .empty (dl_empty)
    );

    // Next-state and next-output logic; outputs are derived from the next state
    // so that each registered output lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_vec_d   = n_vec_q;
        w_valid_d = w_valid_q;
        out_vec_d = out_vec_q + VEC_W'(taps[ROWS]);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_vec_d   = bus.n_vec;
                    cnt_d     = '0;
                    out_vec_d = '0;
                    if (bus.reuse_w && w_valid_q) begin
                        state_d = (bus.n_vec != '0) ? STREAM : DRAIN;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_d = LOAD_W;
                cnt_d   = '0;
            end
            LOAD_W: begin
                if (cnt_q == VEC_W'(ROWS)) begin
                    cnt_d     = '0;
                    w_valid_d = 1'b1;
                    state_d   = (n_vec_q != '0) ? STREAM : DRAIN;
                end else begin
                    cnt_d = cnt_q + VEC_W'(1);
                end
            end
            STREAM: begin
                if (cnt_q == n_vec_q - VEC_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + VEC_W'(1);
                end
            end
            DRAIN: begin
                if (dl_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any trip through CLEAR invalidates the resident tile.
        if (state_d == CLEAR) begin
            w_valid_d = 1'b0;
        end

        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        arr_clr_d     = (state_d == CLEAR);
        wt_rd_en_d    = (state_d == LOAD_W) && (cnt_d < VEC_W'(ROWS));
        wt_rd_row_d   = wt_rd_en_d ? RW'(VEC_W'(ROWS - 1) - cnt_d) : '0;
        ld_weight_d   = (state_d == LOAD_W) && (cnt_d != '0);
        act_rd_en_d   = (state_d == STREAM);
        act_rd_addr_d = act_rd_en_d ? cnt_d : '0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            n_vec_q       <= '0;
            out_vec_q     <= '0;
            act_rd_addr_q <= '0;
            wt_rd_row_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            w_valid_q     <= 1'b0;
            arr_clr_q     <= 1'b0;
            ld_weight_q   <= 1'b0;
            wt_rd_en_q    <= 1'b0;
            act_rd_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            n_vec_q       <= n_vec_d;
            out_vec_q     <= out_vec_d;
            act_rd_addr_q <= act_rd_addr_d;
            wt_rd_row_q   <= wt_rd_row_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            w_valid_q     <= w_valid_d;
            arr_clr_q     <= arr_clr_d;
            ld_weight_q   <= ld_weight_d;
            wt_rd_en_q    <= wt_rd_en_d;
            act_rd_en_q   <= act_rd_en_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.w_valid     = w_valid_q;
    assign bus.arr_clr     = arr_clr_q;
    assign bus.ld_weight   = ld_weight_q;
    assign bus.wt_rd_en    = wt_rd_en_q;
    assign bus.wt_rd_row   = wt_rd_row_q;
    assign bus.act_rd_en   = act_rd_en_q;
    assign bus.act_rd_addr = act_rd_addr_q;
    assign bus.row_valid   = taps[ROWS-1:0];
    assign bus.col_valid   = taps[DEPTH-1:ROWS];
    assign bus.out_vec     = out_vec_q;

endmodule
